roteamento_arbitrado: RTL and testbench
=======================================

// Module: roteamento_arbitrado
// PURPOSE
//  Parametrised N-channel router with a registered output and valid/ready handshake.
//  Generalises the 4:1 combinational routing mux in two ways:
//   - configurable width and channel count;
//   - fixed-select mode (SEL chooses the source) or round-robin arbitration mode.
//  Sits between several producers and one consumer; one word per cycle max throughput.
// PARAMETERS
//  N_BITS  4               data width per channel
//  N_CH    4               number of input channels (>=2)
//  SEL_W   $clog2(N_CH)    width of SEL / Grant (derived, do not override)
// PORTS
//  clock      in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-high reset
//  In_Data    in   N_CH*N_BITS   channel k occupies bits [k*N_BITS +: N_BITS]
//  In_Valid   in   N_CH          channel k offers a word
//  In_Ready   out  N_CH          channel k word accepted this cycle (when valid)
//  Modo       in   1             0 = fixed select, 1 = round-robin
//  SEL        in   SEL_W         source channel in fixed mode; ignored in RR mode
//  Saida      out  N_BITS        registered output data
//  Out_Valid  out  1             Saida holds a valid word
//  Out_Ready  in   1             consumer accepts Saida this cycle
//  Grant      out  SEL_W         channel index that produced the current Saida
// BEHAVIOUR
//  Reset (async, immediate): Saida=0, Out_Valid=0, Grant=0, RR pointer ptr=0; In_Ready=0 while reset is high.
//  Load enable: ld = !Out_Valid || Out_Ready (output register empty or draining this cycle).
//  Fixed mode (Modo=0):
//   - candidate c = SEL;
//   - In_Ready[c] = ld; all other In_Ready = 0;
//   - SEL >= N_CH (non-power-of-2 N_CH): no candidate, all In_Ready = 0.
//  RR mode (Modo=1):
//   - candidate c = first k with In_Valid[k]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1;
//   - In_Ready[c] = ld; others 0; no valid input -> all In_Ready = 0;
//   - on accept, ptr <= (c+1) mod N_CH (wrap at N_CH-1 -> 0);
//   - ptr does not change without an accept, and never changes in fixed mode.
//  Accept: In_Valid[c] && In_Ready[c]. Next edge: Saida <= word of channel c, Grant <= c, Out_Valid <= 1.
//  No accept && Out_Ready && Out_Valid: Out_Valid <= 0. Saida and Grant keep their last value.
//  Latency: 1 cycle from accept to Out_Valid. Back-to-back accepts are allowed while Out_Ready=1.
//  Stall: Out_Valid=1 && Out_Ready=0 -> Saida and Grant held stable; all In_Ready = 0.
//  In_Ready depends combinationally on In_Valid (RR), Modo, SEL, Out_Valid and Out_Ready.
//   Producers must not make In_Valid depend on In_Ready.
//  Modo or SEL change: takes effect on the next arbitration. A word already held in Saida is unaffected.
//  Reset mid-transfer: the held word is dropped and ptr returns to 0.
//  No word is ever duplicated or lost, except on reset.
// TESTING
//  1 Reset: assert reset mid-cycle with Out_Valid=1 -> Out_Valid, Saida, Grant go to 0 immediately, without waiting for a clock edge.
//  2 Fixed mode, N_BITS=4, N_CH=4: SEL=2, ch2=4'hA valid, Out_Ready=1 -> In_Ready=4'b0100; next cycle Saida=A, Grant=2, Out_Valid=1.
//  3 Backpressure: Out_Valid=1, Out_Ready=0 for 3 cycles, ch1 valid -> In_Ready=0; Saida stable.
//      Raise Out_Ready -> ch1 word appears on Saida the following cycle.
//  4 RR fairness: all 4 channels valid (data 1,2,3,4), Out_Ready=1 -> Grant sequence 0,1,2,3,0,... and Saida 1,2,3,4,1,...
//  5 RR skip and wrap: ptr=3, only ch1 valid -> Grant=1, ptr becomes 2.
//      Next: only ch3 and ch0 valid -> Grant=3, then Grant=0 (wrap).
//  6 Mode switch under stall: Saida=5 held from ch2 (Grant=2), switch Modo 0->1 -> Saida stays 5, Grant stays 2 until Out_Ready; next word comes from the RR search.

Source files
------------

// File: rtl/roteamento_arbitrado.sv
// N-channel router with a registered output stage and valid/ready handshake.
// Modo=0 routes the channel chosen by SEL; Modo=1 arbitrates round-robin.
module roteamento_arbitrado #(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH*N_BITS-1:0] In_Data,
  input  logic [N_CH-1:0]        In_Valid,
  output logic [N_CH-1:0]        In_Ready,
  input  logic                   Modo,
  input  logic [SEL_W-1:0]       SEL,
  output logic [N_BITS-1:0]      Saida,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [SEL_W-1:0]       Grant
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  cand;
  logic              cand_ok;
  logic              ld;
  logic              accept;
  logic [SEL_W-1:0]  next_ptr;
  logic [N_BITS-1:0] cand_data;
  int unsigned       idx;

  assign ld = !Out_Valid || Out_Ready;

  // Candidate selection: SEL in fixed mode, first valid channel from ptr onward in RR mode.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    idx     = 0;
    if (!Modo) begin
      if (32'(SEL) < N_CH) begin
        cand    = SEL;
        cand_ok = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = 32'(ptr) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!cand_ok && In_Valid[idx]) begin
          cand    = SEL_W'(idx);
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    In_Ready = '0;
    if (!reset && ld && cand_ok) In_Ready[cand] = 1'b1;
  end

  assign accept    = !reset && ld && cand_ok && In_Valid[cand];
  assign cand_data = In_Data[32'(cand)*N_BITS +: N_BITS];
  assign next_ptr  = (32'(cand) == N_CH - 1) ? '0 : cand + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Saida     <= '0;
      Out_Valid <= 1'b0;
      Grant     <= '0;
      ptr       <= '0;
    end else if (accept) begin
      Saida     <= cand_data;
      Grant     <= cand;
      Out_Valid <= 1'b1;
      if (Modo) ptr <= next_ptr;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roteamento_arbitrado.sv
// Directed-vector bench for roteamento_arbitrado with a queue-based scoreboard
// and a handshake monitor that checks each word the consumer takes.
module tb_roteamento_arbitrado;

  logic        clock;
  logic        reset;
  logic [15:0] In_Data;
  logic [3:0]  In_Valid;
  logic [3:0]  In_Ready;
  logic        Modo;
  logic [1:0]  SEL;
  logic [3:0]  Saida;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [1:0]  Grant;

  int vectors;
  int miscompares;
  logic [5:0] sb_q[$];

  roteamento_arbitrado #(
    .N_BITS(4),
    .N_CH  (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Modo     (Modo),
    .SEL      (SEL),
    .Saida    (Saida),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Grant    (Grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus just after the rising edge and checks In_Ready.
  task automatic drive(input logic modo, input logic [1:0] sel, input logic [3:0] valid,
                       input logic [15:0] data, input logic ordy, input logic [3:0] exp_rdy,
                       input logic push, input logic [3:0] ed, input logic [1:0] eg);
    @(posedge clock);
    #1;
    Modo      = modo;
    SEL       = sel;
    In_Valid  = valid;
    In_Data   = data;
    Out_Ready = ordy;
    #1;
    check("in_ready", 32'(In_Ready), 32'(exp_rdy));
    if (push) sb_q.push_back({ed, eg});
  endtask

  // Monitor: a word leaves when Out_Valid && Out_Ready at the coming edge.
  always @(negedge clock) begin
    logic [5:0] e;
    if (!reset && Out_Valid && Out_Ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon_unexpected: got word %0h grant %0d, expected none", Saida, Grant);
      end else begin
        e = sb_q.pop_front();
        check("mon_saida", 32'(Saida), 32'(e[5:2]));
        check("mon_grant", 32'(Grant), 32'(e[1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    Modo        = 1'b0;
    SEL         = 2'd0;
    In_Valid    = 4'b1111;
    In_Data     = 16'h4321;
    Out_Ready   = 1'b0;
    #2;
    check("rst_out_valid", 32'(Out_Valid), 0);
    check("rst_saida", 32'(Saida), 0);
    check("rst_grant", 32'(Grant), 0);
    check("rst_in_ready", 32'(In_Ready), 0);
    #10;
    reset    = 1'b0;
    In_Valid = 4'b0000;

    // Fixed mode, SEL=2
    drive(1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
    drive(1'b0, 2'd2, 4'b0000, 16'h0000, 1'b1, 4'b0100, 1'b0, 4'h0, 2'd0);
    check("fix_saida", 32'(Saida), 32'hA);
    check("fix_grant", 32'(Grant), 2);
    check("fix_valid", 32'(Out_Valid), 1);

    // Backpressure on ch1
    drive(1'b0, 2'd1, 4'b0010, 16'h0070, 1'b0, 4'b0010, 1'b1, 4'h7, 2'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd1, 4'b0010, 16'h0090, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
      check("stall_saida", 32'(Saida), 32'h7);
      check("stall_grant", 32'(Grant), 1);
    end
    drive(1'b0, 2'd1, 4'b0010, 16'h0090, 1'b1, 4'b0010, 1'b1, 4'h9, 2'd1);
    drive(1'b0, 2'd1, 4'b0000, 16'h0000, 1'b1, 4'b0010, 1'b0, 4'h0, 2'd0);
    check("bp_saida", 32'(Saida), 32'h9);
    drive(1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0);
    check("bp_drained", 32'(Out_Valid), 0);

    // RR fairness, all valid: grants 0,1,2,3,0,1,2
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);

    // ptr=3: only ch1 -> grant 1; then ch3/ch0 -> 3, then wrap to 0
    drive(1'b1, 2'd0, 4'b0010, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
    drive(1'b1, 2'd0, 4'b1001, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
    drive(1'b1, 2'd0, 4'b1001, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    drive(1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
    drive(1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);

    // Mode switch under stall (ptr=1)
    drive(1'b0, 2'd2, 4'b0100, 16'h0500, 1'b0, 4'b0100, 1'b1, 4'h5, 2'd2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
      check("sw_saida", 32'(Saida), 32'h5);
      check("sw_grant", 32'(Grant), 2);
    end
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
    drive(1'b1, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
    drive(1'b1, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);

    // Reset mid-cycle with a held word (ptr=2 beforehand); word is dropped
    drive(1'b0, 2'd3, 4'b1000, 16'hB000, 1'b0, 4'b1000, 1'b0, 4'h0, 2'd0);
    drive(1'b0, 2'd3, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
    check("pre_rst_valid", 32'(Out_Valid), 1);
    check("pre_rst_saida", 32'(Saida), 32'hB);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(Out_Valid), 0);
    check("mid_rst_saida", 32'(Saida), 0);
    check("mid_rst_grant", 32'(Grant), 0);
    check("mid_rst_in_ready", 32'(In_Ready), 0);
    #10;
    reset = 1'b0;
    // ptr back at 0 after reset
    drive(1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    drive(1'b1, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
    drive(1'b1, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
